// File: rtl/counter_sweep_reader_pkg.sv
// Shared types and defaults for the counter sweep reader: FSM state encoding,
// sweep geometry and the accumulator width rule.
package counter_sweep_reader_pkg;

  localparam int DEF_NUM_CNT = 5;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 15;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Three guard bits hold the sum of up to eight full-scale counters.
  function automatic int sum_width(input int data_w);
    return data_w + 3;
  endfunction

  localparam int DEF_SUM_W = sum_width(DEF_DATA_W);

endpackage

// File: rtl/counter_sweep_reader_if.sv
// Request/response port between the sweep reader (master) and the pop-counter
// block (slave): registered req/idx out, same-cycle valid/data back.
interface counter_sweep_reader_if
  import counter_sweep_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              req;
  logic [IDX_W-1:0]  idx;
  logic              cnt_valid;
  logic [DATA_W-1:0] cnt_data;

  modport master (output req, idx, input cnt_valid, cnt_data);
  modport slave  (input req, idx, output cnt_valid, cnt_data);

endinterface

// File: rtl/counter_sweep_reader_stall_timer.sv
// Saturating stall counter; expired flags the increment that would reach
// TIMEOUT so the caller can abort on that same edge.
module stall_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_L,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CW'(TIMEOUT))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = inc && !clr && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/counter_sweep_reader.sv
// Walks the pop-counter indices on start, re-emits each returned value as a
// registered stream with a running total, stalls on missing valid, aborts on timeout.
module counter_sweep_reader
  import counter_sweep_reader_pkg::*;
#(
  parameter int NUM_CNT = DEF_NUM_CNT,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   start,
  counter_sweep_reader_if.master cnt_if,
  output logic                   rd_valid,
  output logic [IDX_W-1:0]       rd_idx,
  output logic [DATA_W-1:0]      rd_data,
  output logic [DATA_W+2:0]      sum,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int SUM_W = sum_width(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

  state_t           state;
  logic             req_q;
  logic [IDX_W-1:0] idx_q;
  logic             stall_expired;
  logic             in_read;

  assign cnt_if.req = req_q;
  assign cnt_if.idx = idx_q;
  assign in_read    = (state == S_READ);

  stall_timer #(.TIMEOUT(TIMEOUT)) u_stall_timer (
    .clk     (clk),
    .reset_L (reset_L),
    .clr     (!in_read || cnt_if.cnt_valid),
    .inc     (in_read && !cnt_if.cnt_valid),
    .expired (stall_expired)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= S_WAIT;
      req_q    <= 1'b0;
      idx_q    <= '0;
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      rd_data  <= '0;
      sum      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_WAIT: begin
          if (start) begin
            state <= S_READ;
            req_q <= 1'b1;
            idx_q <= '0;
            sum   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_READ: begin
          // A returning valid beats a stall that would otherwise hit the timeout.
          if (cnt_if.cnt_valid) begin
            rd_valid <= 1'b1;
            rd_idx   <= idx_q;
            rd_data  <= cnt_if.cnt_data;
            sum      <= sum + SUM_W'(cnt_if.cnt_data);
            if (idx_q == LAST_IDX) begin
              state <= S_DONE;
              req_q <= 1'b0;
              idx_q <= '0;
              done  <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else if (stall_expired) begin
            state <= S_DONE;
            req_q <= 1'b0;
            idx_q <= '0;
            err   <= 1'b1;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_WAIT;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_WAIT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sweep_reader.sv
// Randomized bench for counter_sweep_reader: each sweep is described by per-index
// data and stall lengths, and expected outputs follow from the sweep rules.
module tb_counter_sweep_reader;
  import counter_sweep_reader_pkg::*;

  localparam int NC = 5;
  localparam int DW = 8;
  localparam int TO = 15;

  logic             clk = 1'b0;
  logic             reset_L = 1'b0;
  logic             start = 1'b0;
  logic             rd_valid;
  logic [IDX_W-1:0] rd_idx;
  logic [DW-1:0]    rd_data;
  logic [DW+2:0]    sum;
  logic             busy;
  logic             done;
  logic             err;

  counter_sweep_reader_if #(.DATA_W(DW)) cnt_if ();

  counter_sweep_reader #(.NUM_CNT(NC), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .start    (start),
    .cnt_if   (cnt_if),
    .rd_valid (rd_valid),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .sum      (sum),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  int sw_data  [NC];
  int sw_stall [NC];
  int last_rd_idx  = 0;
  int last_rd_data = 0;
  bit exp_err      = 1'b0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".req"},      int'(cnt_if.req), 0);
    check_eq({tag, ".idx"},      int'(cnt_if.idx), 0);
    check_eq({tag, ".rd_valid"}, int'(rd_valid), 0);
    check_eq({tag, ".rd_idx"},   int'(rd_idx), 0);
    check_eq({tag, ".rd_data"},  int'(rd_data), 0);
    check_eq({tag, ".sum"},      int'(sum), 0);
    check_eq({tag, ".busy"},     int'(busy), 0);
    check_eq({tag, ".done"},     int'(done), 0);
    check_eq({tag, ".err"},      int'(err), 0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One sweep driven from sw_data/sw_stall: index k sees sw_stall[k] cycles of
  // cnt_valid low before its data is presented.
  task automatic run_sweep();
    int  part;
    bit  aborted;
    part    = 0;
    aborted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    cnt_if.cnt_valid = 1'b0;
    step();
    start = 1'b0;
    exp_err = 1'b0;
    check_eq("start.busy", int'(busy), 1);
    check_eq("start.req",  int'(cnt_if.req), 1);
    check_eq("start.idx",  int'(cnt_if.idx), 0);
    check_eq("start.sum",  int'(sum), 0);
    check_eq("start.err",  int'(err), 0);
    check_eq("start.rd_data_hold", int'(rd_data), last_rd_data);
    check_eq("start.rd_idx_hold",  int'(rd_idx), last_rd_idx);

    for (int k = 0; k < NC; k++) begin
      if (!aborted) begin
        for (int s = 0; s < sw_stall[k] && !aborted; s++) begin
          cnt_if.cnt_valid = 1'b0;
          cnt_if.cnt_data  = DW'($urandom);
          start = 1'($urandom_range(0, 1));
          step();
          if (s + 1 >= TO) begin
            aborted = 1'b1;
            exp_err = 1'b1;
            check_eq("abort.done", int'(done), 1);
            check_eq("abort.err",  int'(err), 1);
            check_eq("abort.req",  int'(cnt_if.req), 0);
            check_eq("abort.idx",  int'(cnt_if.idx), 0);
            check_eq("abort.sum",  int'(sum), part);
            check_eq("abort.rd_valid", int'(rd_valid), 0);
          end else begin
            check_eq("stall.req",      int'(cnt_if.req), 1);
            check_eq("stall.idx",      int'(cnt_if.idx), k);
            check_eq("stall.rd_valid", int'(rd_valid), 0);
            check_eq("stall.done",     int'(done), 0);
            check_eq("stall.sum",      int'(sum), part);
          end
        end
        if (!aborted) begin
          cnt_if.cnt_valid = 1'b1;
          cnt_if.cnt_data  = DW'(sw_data[k]);
          start = 1'($urandom_range(0, 1));
          step();
          part        += sw_data[k];
          last_rd_idx  = k;
          last_rd_data = sw_data[k];
          check_eq("cap.rd_valid", int'(rd_valid), 1);
          check_eq("cap.rd_idx",   int'(rd_idx), k);
          check_eq("cap.rd_data",  int'(rd_data), sw_data[k]);
          check_eq("cap.sum",      int'(sum), part);
          check_eq("cap.err",      int'(err), 0);
          if (k == NC - 1) begin
            check_eq("last.done", int'(done), 1);
            check_eq("last.req",  int'(cnt_if.req), 0);
            check_eq("last.idx",  int'(cnt_if.idx), 0);
            check_eq("last.busy", int'(busy), 1);
          end else begin
            check_eq("cap.done", int'(done), 0);
            check_eq("cap.idx",  int'(cnt_if.idx), k + 1);
          end
        end
      end
    end

    // start during the done cycle must be ignored
    cnt_if.cnt_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("end.busy",     int'(busy), 0);
    check_eq("end.done",     int'(done), 0);
    check_eq("end.err",      int'(err), int'(exp_err));
    check_eq("end.sum",      int'(sum), part);
    check_eq("end.rd_valid", int'(rd_valid), 0);
    step();
    check_eq("idle.busy", int'(busy), 0);
    check_eq("idle.req",  int'(cnt_if.req), 0);
    check_eq("idle.err",  int'(err), int'(exp_err));
  endtask

  initial begin
    cnt_if.cnt_valid = 1'b0;
    cnt_if.cnt_data  = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_L = 1'b1;
    step();
    check_all_zero("post_reset");

    for (int k = 0; k < NC; k++) begin sw_data[k] = k + 3; sw_stall[k] = 0; end
    run_sweep();
    check_eq("basic.sum_25", int'(sum), 25);

    for (int k = 0; k < NC; k++) begin sw_data[k] = 255; sw_stall[k] = 0; end
    run_sweep();
    check_eq("max.sum_1275", int'(sum), 1275);

    for (int k = 0; k < NC; k++) begin sw_data[k] = $urandom_range(0, 255); sw_stall[k] = 0; end
    sw_stall[2] = 4;
    run_sweep();

    for (int k = 0; k < NC; k++) begin sw_data[k] = $urandom_range(0, 255); sw_stall[k] = 0; end
    sw_stall[1] = TO;
    run_sweep();
    check_eq("abort.sum_idx0", int'(sum), sw_data[0]);

    for (int k = 0; k < NC; k++) begin sw_data[k] = $urandom_range(0, 255); sw_stall[k] = 0; end
    sw_stall[4] = TO - 1;
    run_sweep();

    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < NC; k++) begin
        sw_data[k]  = $urandom_range(0, 255);
        sw_stall[k] = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
      end
      run_sweep();
    end

    // reset while sitting at idx 3
    @(negedge clk);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cnt_if.cnt_valid = 1'b1;
      cnt_if.cnt_data  = DW'($urandom_range(1, 255));
      step();
    end
    check_eq("midrst.idx_before", int'(cnt_if.idx), 3);
    #2;
    reset_L = 1'b0;
    #1;
    check_all_zero("midrst");
    cnt_if.cnt_valid = 1'b0;
    last_rd_idx  = 0;
    last_rd_data = 0;
    @(negedge clk);
    reset_L = 1'b1;
    step();
    check_eq("midrst.no_done", int'(done), 0);

    for (int k = 0; k < NC; k++) begin sw_data[k] = $urandom_range(0, 255); sw_stall[k] = $urandom_range(0, 2); end
    run_sweep();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/counter_sweep_reader.md
# counter_sweep_reader

Sequencer directly downstream of the QoS PCIe pop-counter block: on a `start` pulse it walks the counter index 0..4 through the counter block's `req`/`idx` request port. It captures each returned `valid`/`data_out` pair and re-emits it as a registered per-counter stream plus a running total. It tolerates the counter block dropping `valid` (main FSM leaving IDLE) by stalling, and aborts with an error flag on timeout.

## Interface
Parameters:
- `NUM_CNT`, 5, number of counters swept (index 0..NUM_CNT-1)
- `DATA_W`, 8, width of counter data returned
- `TIMEOUT`, 15, consecutive stalled cycles tolerated per index before abort

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset_L`  in  1  asynchronous, active-low reset
- `start`  in  1  sweep request; sampled only in S_WAIT
- `cnt_valid`  in  1  `valid` from counter block (same cycle as `req`)
- `cnt_data`  in  DATA_W  `data_out` from counter block
- `req`  out  1  registered request to counter block
- `idx`  out  3  registered counter index to counter block
- `rd_valid`  out  1  one-cycle pulse: `rd_idx`/`rd_data` hold a captured counter
- `rd_idx`  out  3  index of captured counter
- `rd_data`  out  DATA_W  captured counter value
- `sum`  out  DATA_W+3  sum of counters captured this sweep
- `busy`  out  1  high in S_READ and S_DONE
- `done`  out  1  one-cycle pulse at sweep end (normal or abort)
- `err`  out  1  sticky: last sweep aborted on timeout; cleared on next accepted `start`

## Operation
- States: S_WAIT (reset state), S_READ, S_DONE.
- S_WAIT: `start`=1 → S_READ, `idx`=0, `req`=1, `sum`=0, `err`=0, stall count=0. `start` ignored in other states.
- S_READ, `cnt_valid`=1 at edge:
  - capture: `rd_valid`=1, `rd_idx`=`idx`, `rd_data`=`cnt_data`, `sum`+=`cnt_data` (zero-extended), stall count=0.
  - If `idx`=NUM_CNT-1: → S_DONE, `req`=0, `idx`=0. Else `idx`+1.
- S_READ, `cnt_valid`=0 at edge:
  - `idx` and `req` hold, no capture, stall count+1.
  - Stall count reaching TIMEOUT → S_DONE, `err`=1, `req`=0, `idx`=0; `sum` keeps the partial total.
- S_DONE: `done`=1 for exactly one cycle → S_WAIT.
- `sum`, `rd_idx`, `rd_data` hold their last values until the next capture or accepted `start`.
- Width: `sum` is DATA_W+3 bits; 5×255=1275 fits in 11 bits. No saturation needed.
- Stall counter width is clog2(TIMEOUT+1).

## Timing
- Reset (async assert, sync-to-clock release) → S_WAIT, all outputs 0, stall count 0.
- Reset mid-sweep: immediate abort, outputs 0, no `done` pulse.
- Latency: `start` accepted at edge T0 → `req`=1/`idx`=0 after T0. Each stall-free index takes one cycle; `rd_valid` for index k follows edge T(k+1).
- Stall-free sweep: the last capture and `done`=1 both appear after edge T5. `busy` falls after T6.
- `start` high in the same cycle as `done`: ignored (state is S_DONE). `start` after T6 is accepted.
- `cnt_valid` returning on the same edge that the stall count would hit TIMEOUT: capture wins, no abort.

## Structure
- Shared package: state encoding (S_WAIT/S_READ/S_DONE), NUM_CNT, DATA_W, and the derived sum width.
- One natural sub-module: `stall_timer`, a saturating counter with `clr`/`inc` inputs and an `expired` output at TIMEOUT.
- The FSM, capture registers and accumulator live in the top module.

## Test plan
- Reset, then `start` with `cnt_valid`=1 and `cnt_data`=idx+3 → `rd_valid` pulses with data 3,4,5,6,7; `sum`=25; `done` after T5; `err`=0.
- Counters all 255 → `sum`=1275 with no overflow; `rd_data`=255 ×5.
- `cnt_valid` low for 4 cycles at idx 2 → `idx` holds at 2 with `req`=1; sweep completes 4 cycles late; `err`=0; `sum` correct.
- `cnt_valid` low for 15 cycles at idx 1 → `done` pulse, `err`=1, `sum` holds the idx 0 value. Next `start` clears `err`.
- `start` pulsed during S_READ and in the `done` cycle → ignored, no extra sweep.
- `reset_L` low at idx 3 → all outputs 0 asynchronously; after release, `start` restarts the sweep at idx 0.
